// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the gen2 FIFO pointer/flag controller and its reservation sub-block.
package fifo_ctrl_pkg;

  function automatic int unsigned cnt_width(input int unsigned aw);
    return aw + 1;
  endfunction

  // Legal depth range: 2 .. 2**aw entries.
  function automatic bit params_ok(input int unsigned size, input int unsigned aw);
    return (size >= 2) && (aw >= 1) && (aw < 32) &&
           (64'(size) <= (64'd1 << aw));
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic one_from_full;
    logic nearly_full;
    logic nearly_empty;
  } fifo_flags_t;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_errs_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, one_from_full: 1'b0,
                                        nearly_full: 1'b0, nearly_empty: 1'b1};
  localparam fifo_errs_t  ERRS_RST  = '{ovf: 1'b0, udf: 1'b0};

endpackage

// File: rtl/fifo_ctrl_rsv.sv
// Burst space reservation: tracks entries promised to granted bursts but not yet written.
module fifo_ctrl_rsv
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_SIZE = 24,
  parameter int unsigned CW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          we,
  input  logic          rsv_rqst,
  input  logic [CW-1:0] rsv_len,
  input  logic [CW-1:0] count,
  output logic          rsv_gnt,
  output logic [CW-1:0] rsv_cnt_nxt
);

  logic [CW-1:0] rsv_cnt_q;
  logic [CW-1:0] rsv_cnt_d;
  logic [CW-1:0] avail;

  // A write issued in the grant cycle already consumes one of the reserved entries.
  always_comb begin
    avail     = CW'(FIFO_SIZE) - count - rsv_cnt_q;
    rsv_gnt   = rsv_rqst & ~flush & (rsv_len != '0) & (rsv_len <= avail);
    rsv_cnt_d = rsv_cnt_q;
    if (rsv_gnt) rsv_cnt_d = rsv_cnt_d + rsv_len;
    if (we && (rsv_cnt_d != '0)) rsv_cnt_d = rsv_cnt_d - CW'(1);
    if (flush) rsv_cnt_d = '0;
  end

  assign rsv_cnt_nxt = rsv_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsv_cnt_q <= '0;
    else     rsv_cnt_q <= rsv_cnt_d;
  end

endmodule

// File: rtl/fifo_ctrl_gen2.sv
// Gen2 FIFO pointer/flag controller for an external RAM of any depth up to 2**ADDRESS_WIDTH.
// Burst space reservation is built only when FIFO_CTRL_RSV_EN is defined.
module fifo_ctrl_gen2
  import fifo_ctrl_pkg::*;
#(
  parameter  int unsigned FIFO_SIZE     = 24,
  parameter  int unsigned ADDRESS_WIDTH = 5,
  localparam int unsigned CW            = cnt_width(ADDRESS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_rqst,
  input  logic                     rd_rqst,
  input  logic [CW-1:0]            nf_thresh,
  input  logic [CW-1:0]            ne_thresh,
  input  logic                     rsv_rqst,
  input  logic [CW-1:0]            rsv_len,
  output logic                     rsv_gnt,
  output logic [ADDRESS_WIDTH-1:0] wrptr,
  output logic [ADDRESS_WIDTH-1:0] rdptr,
  output logic [CW-1:0]            fifo_count,
  output logic [CW-1:0]            fifo_free,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_one_from_full,
  output logic                     fifo_nearly_full,
  output logic                     fifo_nearly_empty,
  output logic                     ovf_err,
  output logic                     udf_err
);

  localparam int unsigned     AW       = ADDRESS_WIDTH;
  localparam logic [CW-1:0]   SIZE_C   = CW'(FIFO_SIZE);
  localparam logic [AW-1:0]   LAST_PTR = AW'(FIFO_SIZE - 1);

  if (!params_ok(FIFO_SIZE, ADDRESS_WIDTH)) begin : g_bad_params
    $error("fifo_ctrl_gen2: FIFO_SIZE must be within 2..2**ADDRESS_WIDTH");
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  logic [AW-1:0] wrptr_q, wrptr_d;
  logic [AW-1:0] rdptr_q, rdptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_q, free_d;
  fifo_flags_t   flags_q, flags_d;
  fifo_errs_t    errs_q, errs_d;
  logic          we;
  logic          re;
  logic [CW-1:0] rsv_cnt_nxt;

`ifdef FIFO_CTRL_RSV_EN
  fifo_ctrl_rsv #(
    .FIFO_SIZE (FIFO_SIZE),
    .CW        (CW)
  ) u_rsv (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .we          (we),
    .rsv_rqst    (rsv_rqst),
    .rsv_len     (rsv_len),
    .count       (count_q),
    .rsv_gnt     (rsv_gnt),
    .rsv_cnt_nxt (rsv_cnt_nxt)
  );
`else
  logic unused_rsv;
  assign unused_rsv  = ^{rsv_rqst, rsv_len};
  assign rsv_gnt     = 1'b0;
  assign rsv_cnt_nxt = '0;
`endif

  // Next-state: gated requests, pointer wrap at FIFO_SIZE-1, flags from the next count.
  always_comb begin
    we      = wr_rqst & ~flags_q.full;
    re      = rd_rqst & ~flags_q.empty;
    wrptr_d = we ? ptr_inc(wrptr_q) : wrptr_q;
    rdptr_d = re ? ptr_inc(rdptr_q) : rdptr_q;
    count_d = count_q + CW'(we) - CW'(re);
    free_d  = SIZE_C - count_d - rsv_cnt_nxt;

    flags_d.full          = (count_d == SIZE_C);
    flags_d.empty         = (count_d == '0);
    flags_d.one_from_full = (count_d == SIZE_C - CW'(1));
    flags_d.nearly_full   = (count_d >= nf_thresh);
    flags_d.nearly_empty  = (count_d <= ne_thresh);

    errs_d.ovf = errs_q.ovf | (wr_rqst & flags_q.full);
    errs_d.udf = errs_q.udf | (rd_rqst & flags_q.empty);

    if (flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
      free_d  = SIZE_C;
      flags_d = FLAGS_RST;
      errs_d  = ERRS_RST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      free_q  <= SIZE_C;
      flags_q <= FLAGS_RST;
      errs_q  <= ERRS_RST;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      free_q  <= free_d;
      flags_q <= flags_d;
      errs_q  <= errs_d;
    end
  end

  assign wrptr              = wrptr_q;
  assign rdptr              = rdptr_q;
  assign fifo_count         = count_q;
  assign fifo_free          = free_q;
  assign fifo_full          = flags_q.full;
  assign fifo_empty         = flags_q.empty;
  assign fifo_one_from_full = flags_q.one_from_full;
  assign fifo_nearly_full   = flags_q.nearly_full;
  assign fifo_nearly_empty  = flags_q.nearly_empty;
  assign ovf_err            = errs_q.ovf;
  assign udf_err            = errs_q.udf;

endmodule

// File: tb/tb_fifo_ctrl_gen2.sv
// Scoreboard bench for fifo_ctrl_gen2 (FIFO_SIZE=24, ADDRESS_WIDTH=5); honours FIFO_CTRL_RSV_EN.
`timescale 1ns/1ps
module tb_fifo_ctrl_gen2;

  localparam int unsigned SIZE = 24;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned OW   = 2*AW + 2*CW + 7;
`ifdef FIFO_CTRL_RSV_EN
  localparam bit RSV = 1'b1;
`else
  localparam bit RSV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, wr_rqst, rd_rqst, rsv_rqst, rsv_gnt;
  logic [CW-1:0] nf_thresh, ne_thresh, rsv_len, fifo_count, fifo_free;
  logic [AW-1:0] wrptr, rdptr;
  logic          fifo_full, fifo_empty, fifo_one_from_full, fifo_nearly_full, fifo_nearly_empty;
  logic          ovf_err, udf_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] sb[$];
  int m_cnt, m_wp, m_rp, m_rsv;
  bit m_ovf, m_udf, gnt_exp, gnt_seen;

  always #5 clk = ~clk;

  fifo_ctrl_gen2 #(.FIFO_SIZE(SIZE), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_rqst(wr_rqst), .rd_rqst(rd_rqst),
    .nf_thresh(nf_thresh), .ne_thresh(ne_thresh), .rsv_rqst(rsv_rqst), .rsv_len(rsv_len),
    .rsv_gnt(rsv_gnt), .wrptr(wrptr), .rdptr(rdptr), .fifo_count(fifo_count),
    .fifo_free(fifo_free), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_one_from_full(fifo_one_from_full), .fifo_nearly_full(fifo_nearly_full),
    .fifo_nearly_empty(fifo_nearly_empty), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  function automatic logic [OW-1:0] get_obs();
    return {wrptr, rdptr, fifo_count, fifo_free, fifo_full, fifo_empty, fifo_one_from_full,
            fifo_nearly_full, fifo_nearly_empty, ovf_err, udf_err};
  endfunction

  function automatic logic [OW-1:0] reset_vec();
    return {AW'(0), AW'(0), CW'(0), CW'(SIZE), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [OW-1:0] model_vec();
    return {AW'(m_wp), AW'(m_rp), CW'(m_cnt), CW'(int'(SIZE) - m_cnt - m_rsv),
            m_cnt == int'(SIZE), m_cnt == 0, m_cnt == int'(SIZE) - 1,
            m_cnt >= int'(nf_thresh), m_cnt <= int'(ne_thresh), m_ovf, m_udf};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_rsv = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, push it, then cross the edge.
  task automatic step(input bit w, input bit r, input bit f, input bit rq, input int len);
    bit full_m, empty_m, we, re;
    wr_rqst = w; rd_rqst = r; flush = f; rsv_rqst = rq; rsv_len = CW'(len);
    full_m  = (m_cnt == int'(SIZE));
    empty_m = (m_cnt == 0);
    we = w && !full_m;
    re = r && !empty_m;
    gnt_exp = RSV && rq && !f && (len != 0) && (len <= int'(SIZE) - m_cnt - m_rsv);
    #1;
    gnt_seen = rsv_gnt;
    if (f) begin
      model_reset();
      sb.push_back(reset_vec());
    end else begin
      if (gnt_exp) m_rsv += len;
      if (we && m_rsv > 0) m_rsv--;
      m_ovf = m_ovf | (w && full_m);
      m_udf = m_udf | (r && empty_m);
      m_cnt += int'(we) - int'(re);
      if (we) m_wp = (m_wp == int'(SIZE) - 1) ? 0 : m_wp + 1;
      if (re) m_rp = (m_rp == int'(SIZE) - 1) ? 0 : m_rp + 1;
      sb.push_back(model_vec());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (get_obs() !== reset_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", get_obs(), reset_vec());
    end
    n_checks++;
    if (rsv_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 0", rsv_gnt);
    end
  endtask

  task automatic test_fill();
    logic [OW-1:0] e, o;
    for (int i = 1; i <= int'(SIZE); i++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL fill[%0d]: got %h want %h", i, o, e); end
      if (i == int'(SIZE) - 1) begin
        n_checks++;
        if ({fifo_one_from_full, fifo_full, wrptr} !== {1'b1, 1'b0, AW'(23)}) begin
          n_fail++; $display("FAIL fill_23: got off=%b full=%b wp=%0d want 1 0 23",
                             fifo_one_from_full, fifo_full, wrptr);
        end
      end
    end
    n_checks++;
    if ({fifo_one_from_full, fifo_full, wrptr} !== {1'b0, 1'b1, AW'(0)}) begin
      n_fail++; $display("FAIL fill_24: got off=%b full=%b wp=%0d want 0 1 0",
                         fifo_one_from_full, fifo_full, wrptr);
    end
  endtask

  task automatic test_full_rdwr();
    logic [OW-1:0] e, o;
    step(1, 1, 0, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL full_rdwr: got %h want %h", o, e); end
    n_checks++;
    if ({fifo_count, ovf_err} !== {CW'(23), 1'b1}) begin
      n_fail++; $display("FAIL full_rdwr_ovf: got cnt=%0d ovf=%b want 23 1", fifo_count, ovf_err);
    end
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, 0, 0);
      e = sb.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL drain[%0d]: got %h want %h", i, o, e); end
    end
    n_checks++;
    if ({fifo_count, fifo_empty} !== {CW'(14), 1'b0}) begin
      n_fail++; $display("FAIL drain_end: got cnt=%0d empty=%b want 14 0", fifo_count, fifo_empty);
    end
  endtask

  task automatic test_underflow_flush();
    logic [OW-1:0] e, o;
    step(0, 0, 1, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL flush1: got %h want %h", o, e); end
    step(0, 1, 0, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL udf: got %h want %h", o, e); end
    n_checks++;
    if ({udf_err, fifo_count} !== {1'b1, CW'(0)}) begin
      n_fail++; $display("FAIL udf_flag: got udf=%b cnt=%0d want 1 0", udf_err, fifo_count);
    end
    step(1, 0, 0, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL udf_wr: got %h want %h", o, e); end
    step(1, 1, 1, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL flush2: got %h want %h", o, e); end
    n_checks++;
    if ({udf_err, wrptr, rdptr, fifo_empty} !== {1'b0, AW'(0), AW'(0), 1'b1}) begin
      n_fail++; $display("FAIL flush_clr: got udf=%b wp=%0d rp=%0d empty=%b want 0 0 0 1",
                         udf_err, wrptr, rdptr, fifo_empty);
    end
  endtask

  task automatic test_thresh();
    logic [OW-1:0] e, o;
    nf_thresh = CW'(16); ne_thresh = CW'(4);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL th_fill[%0d]: got %h want %h", i, o, e); end
    end
    n_checks++;
    if (fifo_nearly_full !== 1'b0) begin
      n_fail++; $display("FAIL th_nf16: got %b want 0", fifo_nearly_full);
    end
    nf_thresh = CW'(15);
    step(0, 0, 0, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL th_nf_step: got %h want %h", o, e); end
    n_checks++;
    if (fifo_nearly_full !== 1'b1) begin
      n_fail++; $display("FAIL th_nf15: got %b want 1", fifo_nearly_full);
    end
    ne_thresh = CW'(15);
    step(0, 0, 0, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL th_ne_step: got %h want %h", o, e); end
    n_checks++;
    if (fifo_nearly_empty !== 1'b1) begin
      n_fail++; $display("FAIL th_ne15: got %b want 1", fifo_nearly_empty);
    end
    nf_thresh = CW'(20); ne_thresh = CW'(4);
  endtask

  task automatic test_rsv();
    logic [OW-1:0] e, o;
    step(0, 0, 1, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rsv_pre[%0d]: got %h want %h", i, o, e); end
    end
    step(0, 0, 0, 1, 16);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (gnt_seen !== RSV) begin n_fail++; $display("FAIL rsv_gnt16: got %b want %b", gnt_seen, RSV); end
    n_checks++;
    if (fifo_free !== (RSV ? CW'(4) : CW'(20))) begin
      n_fail++; $display("FAIL rsv_free16: got %0d want %0d", fifo_free, RSV ? 4 : 20);
    end
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL rsv_sb16: got %h want %h", o, e); end
    step(0, 0, 0, 1, 5);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (gnt_seen !== 1'b0) begin n_fail++; $display("FAIL rsv_gnt5: got %b want 0", gnt_seen); end
    step(0, 0, 0, 1, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (gnt_seen !== 1'b0) begin n_fail++; $display("FAIL rsv_gnt0: got %b want 0", gnt_seen); end
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rsv_wr[%0d]: got %h want %h", i, o, e); end
    end
    n_checks++;
    if ({fifo_count, fifo_free} !== {CW'(20), CW'(4)}) begin
      n_fail++; $display("FAIL rsv_end: got cnt=%0d free=%0d want 20 4", fifo_count, fifo_free);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e, o;
    int wp;
    for (int i = 0; i < 400; i++) begin
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      if (i % 40 == 39) begin
        nf_thresh = CW'($urandom_range(0, SIZE));
        ne_thresh = CW'($urandom_range(0, SIZE));
      end
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp,
           $urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, SIZE)));
      e = sb.pop_front(); o = get_obs(); n_checks++;
      if (o !== e || gnt_seen !== gnt_exp) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h gnt %b want %h gnt %b", i, o, gnt_seen, e, gnt_exp);
      end
    end
    nf_thresh = CW'(20); ne_thresh = CW'(4);
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] e, o;
    step(0, 0, 1, 0, 0);
    void'(sb.pop_front());
    step(0, 0, 0, 1, 16);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL ar_rsv: got %h want %h", o, e); end
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 0, 0);
      e = sb.pop_front(); o = get_obs(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL ar_wr[%0d]: got %h want %h", i, o, e); end
    end
    wr_rqst = 1'b0; rsv_rqst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (get_obs() !== reset_vec()) begin
      n_fail++; $display("FAIL async_rst: got %h want %h", get_obs(), reset_vec());
    end
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    e = sb.pop_front(); o = get_obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL ar_after: got %h want %h", o, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wr_rqst = 1'b0; rd_rqst = 1'b0; rsv_rqst = 1'b0;
    rsv_len = '0; nf_thresh = CW'(20); ne_thresh = CW'(4);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_fill();
    test_full_rdwr();
    test_underflow_flush();
    test_thresh();
    test_rsv();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
